pipeline_arith: RTL and testbench

PIPELINE_ARITH -- requirements
Module: pipeline_arith

---
 rtl/pipeline_arith.sv | 100 ++++++++++
 tb/tb_pipeline_arith.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_arith.sv
// Three-stage arithmetic pipeline: F = op(((A+B)+(C-D)), D) selected by mode.
// Valid/ready handshake on both sides, with synchronous flush and result counter.
module pipeline_arith #(
  parameter int unsigned N  = 10,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic [N-1:0]  C,
  input  logic [N-1:0]  D,
  input  logic [1:0]    mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  F,
  output logic [CW-1:0] res_cnt
);

  logic          r_s1_vld, r_s2_vld, r_s3_vld;
  logic [N-1:0]  r_x1, r_x2, r_s1_d;
  logic [1:0]    r_s1_mode;
  logic [N-1:0]  r_x3, r_s2_d;
  logic [1:0]    r_s2_mode;
  logic [N-1:0]  r_f;
  logic [CW-1:0] r_cnt;

  logic          w_adv;
  logic          w_acc;
  logic [N-1:0]  w_res;

  assign w_adv     = !r_s3_vld || out_ready;
  assign in_ready  = w_adv && !flush;
  assign w_acc     = in_valid && in_ready;
  assign out_valid = r_s3_vld;
  assign F         = r_f;
  assign res_cnt   = r_cnt;

  always_comb begin
    w_res = r_x3;
    unique case (r_s2_mode)
      2'd0:    w_res = r_x3 * r_s2_d;
      2'd1:    w_res = r_x3 + r_s2_d;
      2'd2:    w_res = r_x3 - r_s2_d;
      default: w_res = r_x3;
    endcase
  end

  // Valid bits: flush clears them even while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
    end else if (flush) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
    end else if (w_adv) begin
      r_s1_vld <= w_acc;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
    end
  end

  // Data registers need no flush handling; stale contents are masked by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x1      <= '0;
      r_x2      <= '0;
      r_s1_d    <= '0;
      r_s1_mode <= '0;
      r_x3      <= '0;
      r_s2_d    <= '0;
      r_s2_mode <= '0;
      r_f       <= '0;
    end else if (w_adv) begin
      r_x1      <= A + B;
      r_x2      <= C - D;
      r_s1_d    <= D;
      r_s1_mode <= mode;
      r_x3      <= r_x1 + r_x2;
      r_s2_d    <= r_s1_d;
      r_s2_mode <= r_s1_mode;
      r_f       <= w_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_s3_vld && out_ready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_arith.sv
// Directed bench for pipeline_arith: basic op, wraparound, backpressure, flush,
// mid-run reset and result-counter wrap.
module tb_pipeline_arith;

  localparam int unsigned N  = 10;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  A, B, C, D, F;
  logic [1:0]    mode;
  logic [CW-1:0] res_cnt;

  int total = 0;
  int bad   = 0;

  pipeline_arith #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .F         (F),
    .res_cnt   (res_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int a, input int b, input int c, input int d,
                       input int m);
    in_valid = v;
    A        = N'(a);
    B        = N'(b);
    C        = N'(c);
    D        = N'(d);
    mode     = 2'(m);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 5, 5, 5, 1, 1);  // presented during reset: must be dropped
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_F", 32'(F), 0);
    chk("rst_res_cnt", 32'(res_cnt), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);
    step(); step(); step();
    chk("rst_no_leak", 32'(out_valid), 0);

    // Basic: (3+4)+(10-2)=15, *2 = 30
    drive(1'b1, 3, 4, 10, 2, 0);
    step();
    drive(1'b0, 0, 0, 0, 0, 0);
    step();
    chk("basic_lat_early", 32'(out_valid), 0);
    step();
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_F", 32'(F), 30);
    chk("basic_cnt_pre", 32'(res_cnt), 0);
    step();
    chk("basic_cnt", 32'(res_cnt), 1);
    chk("basic_drained", 32'(out_valid), 0);

    // Wrap: x1=0, x2=1023, x3=1023
    drive(1'b1, 1023, 1, 0, 1, 0); step();
    drive(1'b1, 1023, 1, 0, 1, 1); step();
    drive(1'b1, 1023, 1, 0, 1, 2); step();
    chk("wrap_m0", 32'(F), 1023);
    drive(1'b1, 1023, 1, 0, 1, 3); step();
    chk("wrap_m1", 32'(F), 0);
    drive(1'b0, 0, 0, 0, 0, 0); step();
    chk("wrap_m2", 32'(F), 1022);
    step();
    chk("wrap_m3", 32'(F), 1023);
    chk("wrap_m3_valid", 32'(out_valid), 1);
    step();
    chk("wrap_drained", 32'(out_valid), 0);
    chk("wrap_cnt", 32'(res_cnt), 5);

    // Backpressure: A=10i, B=1, C=5, D=2, mode 1 -> F = 10i+6
    drive(1'b1, 10, 1, 5, 2, 1); step();
    drive(1'b1, 20, 1, 5, 2, 1); step();
    drive(1'b1, 30, 1, 5, 2, 1); step();
    chk("bp_r1", 32'(F), 16);
    out_ready = 1'b0;
    drive(1'b1, 40, 1, 5, 2, 1);
    #1;
    chk("bp_in_ready_stall0", 32'(in_ready), 0);
    step();
    chk("bp_hold0_F", 32'(F), 16);
    chk("bp_hold0_valid", 32'(out_valid), 1);
    chk("bp_in_ready_stall1", 32'(in_ready), 0);
    step();
    chk("bp_hold1_F", 32'(F), 16);
    chk("bp_cnt_stall", 32'(res_cnt), 5);
    out_ready = 1'b1;
    step();
    chk("bp_r2", 32'(F), 26);
    drive(1'b1, 50, 1, 5, 2, 1); step();
    chk("bp_r3", 32'(F), 36);
    drive(1'b0, 0, 0, 0, 0, 0); step();
    chk("bp_r4", 32'(F), 46);
    step();
    chk("bp_r5", 32'(F), 56);
    step();
    chk("bp_drained", 32'(out_valid), 0);
    chk("bp_cnt", 32'(res_cnt), 10);

    // Flush with 3 in flight (stalled, no handshake) and a 4th presented
    out_ready = 1'b0;
    drive(1'b1, 10, 1, 5, 2, 1); step();
    drive(1'b1, 20, 1, 5, 2, 1); step();
    drive(1'b1, 30, 1, 5, 2, 1); step();
    chk("fl_full", 32'(out_valid), 1);
    drive(1'b1, 40, 1, 5, 2, 1);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 0);
    step();
    chk("fl_valid_clr", 32'(out_valid), 0);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fl_none", 32'(out_valid), 0);
    end
    chk("fl_cnt", 32'(res_cnt), 10);

    // Reset with two sets in flight
    drive(1'b1, 3, 4, 10, 2, 0); step();
    drive(1'b1, 3, 4, 10, 2, 1); step();
    drive(1'b0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    chk("mrst_F", 32'(F), 0);
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_cnt", 32'(res_cnt), 0);
    rst = 1'b0;
    step();
    chk("mrst_no_leak", 32'(out_valid), 0);
    drive(1'b1, 3, 4, 10, 2, 0); step();
    drive(1'b0, 0, 0, 0, 0, 0); step(); step();
    chk("mrst_after_valid", 32'(out_valid), 1);
    chk("mrst_after_F", 32'(F), 30);

    // Counter wrap: 1 pending + 65535 streamed results = 65536 handshakes
    drive(1'b1, 1, 2, 3, 1, 3);
    for (int i = 0; i < 65535; i++) step();
    drive(1'b0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("cw_last_valid", 32'(out_valid), 1);
    chk("cw_pre_wrap", 32'(res_cnt), 65535);
    step();
    chk("cw_wrapped", 32'(res_cnt), 0);
    chk("cw_drained", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
